sm4_ck_gen: RTL and testbench
=============================

SM4_CK_GEN -- requirements
Module: sm4_ck_gen

Interface
REQ-001 SHALL have parameter LANES, default 1, meaning CK words emitted per beat; legal values 1, 2, 4.
REQ-002 SHALL have parameter NUM_ROUNDS, default 32, meaning rounds per sequence; legal values are multiples of LANES in the range 8..32.
REQ-003 SHALL have parameter RW, default 5, meaning the round-index width; RW = ceil(log2(NUM_ROUNDS)).
REQ-004 clk_sys  input  1  system clock; all state updates on its rising edge.
REQ-005 rst_sys  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  begin a sequence; sampled only in IDLE.
REQ-007 dir  input  1  order: 0 = forward (encrypt/key expansion), 1 = reverse (decrypt); sampled with start.
REQ-008 abort  input  1  synchronous cancel of the current sequence.
REQ-009 ck_ready  input  1  consumer accepts the current beat.
REQ-010 ck_valid  output  1  ck_data, round_idx and ck_last are valid.
REQ-011 ck_data  output  32*LANES  CK words; lane k occupies bits [32k+31:32k].
REQ-012 round_idx  output  RW  round number of lane 0.
REQ-013 ck_last  output  1  final beat of the sequence.
REQ-014 busy  output  1  high in RUN.
REQ-015 done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-016 CK byte j of round i (j = 0 is the MSB byte) SHALL equal (4i+j)*7 mod 256, e.g. CK0 = 00070e15, CK31 = 646b7279.
REQ-017 CK SHALL be generated arithmetically from a registered 8-bit base byte (28*i mod 256), which steps by +28*LANES forward or -28*LANES reverse, modulo 256; a 32-entry lookup table SHALL NOT be used.
REQ-018 Lane k SHALL carry the k-th next round in consumption order: round_idx+k forward, round_idx-k reverse.
REQ-019 The FSM SHALL have states IDLE and RUN; done SHALL be a registered pulse, not a state.
REQ-020 IDLE to RUN SHALL occur on start=1 with abort=0, latching dir.
  - round_idx loads 0 if dir=0, NUM_ROUNDS-1 if dir=1.
  - ck_valid rises the following cycle; start-to-first-valid latency is 1 cycle.
REQ-021 In RUN, ck_valid SHALL stay high; outputs SHALL hold stable while ck_ready=0.
REQ-022 A beat is accepted when ck_valid and ck_ready are both high.
  - round_idx advances by LANES (forward) or retreats by LANES (reverse) on the next edge.
  - Back-to-back acceptance SHALL sustain one beat per cycle.
REQ-023 ck_last SHALL be high on the beat containing round NUM_ROUNDS-1 (forward) or round 0 (reverse).
REQ-024 Acceptance of the ck_last beat SHALL return the FSM to IDLE, drop ck_valid, and pulse done for exactly one cycle.
REQ-025 start in RUN SHALL be ignored; a start coinciding with the done cycle SHALL be honoured (IDLE is entered at that edge).
REQ-026 abort=1 in RUN SHALL force IDLE on the next edge, clear ck_valid, and produce no done pulse; abort has priority over a simultaneous accept.
REQ-027 abort=1 in IDLE SHALL block start in the same cycle.
REQ-028 In IDLE, ck_data, round_idx and ck_last SHALL be driven to 0.
REQ-029 Round-index arithmetic SHALL be RW bits wide and SHALL never wrap within a legal sequence.

Reset
REQ-030 rst_sys=1 SHALL immediately force IDLE, with ck_valid=0, ck_data=0, round_idx=0, ck_last=0, busy=0, done=0, base byte=0, and latched dir=0.
REQ-031 Reset asserted mid-sequence SHALL discard the sequence; no done pulse SHALL follow deassertion.
REQ-032 After reset deassertion the block SHALL accept start on the first clock edge.

Verification
REQ-033 LANES=1, dir=0, ck_ready tied high -> 32 consecutive beats CK0..CK31 (00070e15 ... 646b7279), ck_last on round 31, done one cycle later.
REQ-034 LANES=4, dir=1 -> 8 beats; first beat ck_data = {CK28, CK29, CK30, CK31} (lane0 = CK31 = 646b7279, lane3 = CK28 = 10171e25), round_idx 31; last beat round_idx 3.
REQ-035 LANES=2, random ck_ready stalls -> outputs stable during stalls, no skipped or duplicated rounds, 16 accepted beats total.
REQ-036 abort asserted together with an accept at round 10 -> IDLE next cycle, ck_valid=0, no done; a new start restarts at CK0.
REQ-037 rst_sys pulsed asynchronously mid-sequence between clock edges -> all outputs 0 immediately, no done pulse after release.
REQ-038 start asserted in the done cycle -> a new sequence begins with ck_valid high on the next cycle at round 0 (forward).

Source files
------------

// File: rtl/sm4_ck_gen_if.sv
// Handshake bundle between the SM4 CK generator and its consumer.
interface sm4_ck_gen_if #(
    parameter int unsigned LANES = 1,
    parameter int unsigned RW    = 5
);
    logic                  start;
    logic                  dir;
    logic                  abort;
    logic                  ck_ready;
    logic                  ck_valid;
    logic [32*LANES-1:0]   ck_data;
    logic [RW-1:0]         round_idx;
    logic                  ck_last;
    logic                  busy;
    logic                  done;

    modport master (
        output start, dir, abort, ck_ready,
        input  ck_valid, ck_data, round_idx, ck_last, busy, done
    );

    modport slave (
        input  start, dir, abort, ck_ready,
        output ck_valid, ck_data, round_idx, ck_last, busy, done
    );
endinterface

// File: rtl/sm4_ck_gen.sv
// SM4 key-schedule constant (CK) generator: streams CK words in forward or
// reverse round order, LANES words per beat, computed from a running base byte.
module sm4_ck_gen #(
    parameter int unsigned LANES      = 1,
    parameter int unsigned NUM_ROUNDS = 32,
    parameter int unsigned RW         = 5
) (
    input  logic          clk_sys,
    input  logic          rst_sys,
    sm4_ck_gen_if.slave   ck_if
);
    localparam int unsigned    DW        = 32 * LANES;
    localparam logic [7:0]     STEP      = 8'((28 * LANES) % 256);
    localparam logic [7:0]     BASE_TOP  = 8'((28 * (NUM_ROUNDS - 1)) % 256);
    localparam logic [RW-1:0]  IDX_TOP   = RW'(NUM_ROUNDS - 1);
    localparam logic [RW-1:0]  IDX_STEP  = RW'(LANES);
    localparam logic [RW-1:0]  LAST_FWD  = RW'(NUM_ROUNDS - LANES);
    localparam logic [RW-1:0]  LAST_REV  = RW'(LANES - 1);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e          state_q;
    logic            dir_q, dir_d;
    logic [RW-1:0]   idx_q, idx_d;
    logic [7:0]      base_q, base_d;
    logic [DW-1:0]   data_q;
    logic            last_q;
    logic            done_q;
    logic            launch_c, accept_c, abort_c, finish_c, advance_c;

    // Byte j of a round is base + 7j, since (4i+j)*7 = 28i + 7j.
    function automatic logic [31:0] ck_word(input logic [7:0] b);
        return {b, 8'(b + 8'd7), 8'(b + 8'd14), 8'(b + 8'd21)};
    endfunction

    function automatic logic [DW-1:0] beat_word(input logic [7:0] b, input logic d);
        logic [DW-1:0] w;
        logic [7:0]    lb;
        w = '0;
        for (int k = 0; k < LANES; k++) begin
            lb = d ? 8'(b - 8'(28 * k)) : 8'(b + 8'(28 * k));
            w[32*k +: 32] = ck_word(lb);
        end
        return w;
    endfunction

    always_comb begin
        launch_c  = (state_q == S_IDLE) && ck_if.start && !ck_if.abort;
        abort_c   = (state_q == S_RUN) && ck_if.abort;
        accept_c  = (state_q == S_RUN) && ck_if.ck_ready && !ck_if.abort;
        finish_c  = accept_c && last_q;
        advance_c = accept_c && !last_q;
        dir_d     = launch_c ? ck_if.dir : dir_q;
        idx_d     = idx_q;
        base_d    = base_q;
        if (launch_c) begin
            idx_d  = ck_if.dir ? IDX_TOP  : '0;
            base_d = ck_if.dir ? BASE_TOP : 8'd0;
        end else if (abort_c || finish_c) begin
            // Clearing here keeps the index from stepping past the last round.
            idx_d  = '0;
            base_d = 8'd0;
        end else if (advance_c) begin
            idx_d  = dir_q ? RW'(idx_q - IDX_STEP) : RW'(idx_q + IDX_STEP);
            base_d = dir_q ? 8'(base_q - STEP) : 8'(base_q + STEP);
        end
    end

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            idx_q   <= '0;
            base_q  <= 8'd0;
            data_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            dir_q  <= dir_d;
            idx_q  <= idx_d;
            base_q <= base_d;
            done_q <= finish_c;
            if (launch_c || advance_c) begin
                state_q <= S_RUN;
                data_q  <= beat_word(base_d, dir_d);
                last_q  <= dir_d ? (idx_d == LAST_REV) : (idx_d == LAST_FWD);
            end else if (abort_c || finish_c) begin
                state_q <= S_IDLE;
                data_q  <= '0;
                last_q  <= 1'b0;
            end
        end
    end

    assign ck_if.ck_valid  = (state_q == S_RUN);
    assign ck_if.busy      = (state_q == S_RUN);
    assign ck_if.ck_data   = data_q;
    assign ck_if.round_idx = idx_q;
    assign ck_if.ck_last   = last_q;
    assign ck_if.done      = done_q;
endmodule

// File: tb/tb_sm4_ck_gen.sv
// Bench for sm4_ck_gen: three lane widths checked against a formula-level CK model.
module tb_sm4_ck_gen;
    localparam int unsigned NR = 32;
    localparam int unsigned RW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic start_v [3];
    logic dir_v   [3];
    logic abort_v [3];
    logic ready_v [3];

    logic [127:0]  obs_data  [3];
    logic [RW-1:0] obs_idx   [3];
    logic          obs_valid [3];
    logic          obs_last  [3];
    logic          obs_busy  [3];
    logic          obs_done  [3];

    sm4_ck_gen_if #(.LANES(1), .RW(RW)) if1 ();
    sm4_ck_gen_if #(.LANES(2), .RW(RW)) if2 ();
    sm4_ck_gen_if #(.LANES(4), .RW(RW)) if4 ();

    sm4_ck_gen #(.LANES(1), .NUM_ROUNDS(NR), .RW(RW)) u1 (.clk_sys(clk), .rst_sys(rst), .ck_if(if1));
    sm4_ck_gen #(.LANES(2), .NUM_ROUNDS(NR), .RW(RW)) u2 (.clk_sys(clk), .rst_sys(rst), .ck_if(if2));
    sm4_ck_gen #(.LANES(4), .NUM_ROUNDS(NR), .RW(RW)) u4 (.clk_sys(clk), .rst_sys(rst), .ck_if(if4));

    assign if1.start = start_v[0]; assign if1.dir = dir_v[0];
    assign if1.abort = abort_v[0]; assign if1.ck_ready = ready_v[0];
    assign if2.start = start_v[1]; assign if2.dir = dir_v[1];
    assign if2.abort = abort_v[1]; assign if2.ck_ready = ready_v[1];
    assign if4.start = start_v[2]; assign if4.dir = dir_v[2];
    assign if4.abort = abort_v[2]; assign if4.ck_ready = ready_v[2];

    assign obs_data[0] = 128'(if1.ck_data);
    assign obs_data[1] = 128'(if2.ck_data);
    assign obs_data[2] = if4.ck_data;
    assign obs_idx[0] = if1.round_idx; assign obs_idx[1] = if2.round_idx; assign obs_idx[2] = if4.round_idx;
    assign obs_valid[0] = if1.ck_valid; assign obs_valid[1] = if2.ck_valid; assign obs_valid[2] = if4.ck_valid;
    assign obs_last[0] = if1.ck_last; assign obs_last[1] = if2.ck_last; assign obs_last[2] = if4.ck_last;
    assign obs_busy[0] = if1.busy; assign obs_busy[1] = if2.busy; assign obs_busy[2] = if4.busy;
    assign obs_done[0] = if1.done; assign obs_done[1] = if2.done; assign obs_done[2] = if4.done;

    function automatic int lanes_of(input int n);
        return (n == 0) ? 1 : ((n == 1) ? 2 : 4);
    endfunction

    // Reference CK: byte j of round i is (4i+j)*7 mod 256, MSB byte first.
    function automatic logic [31:0] ck_ref(input int i);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
        return w;
    endfunction

    function automatic logic [127:0] beat_ref(input int i, input int lanes, input bit d);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < lanes; k++) w[32*k +: 32] = ck_ref(d ? i - k : i + k);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle(input int n, input string tag);
        chk({tag, "_valid"}, 128'(obs_valid[n]), 128'(0));
        chk({tag, "_busy"},  128'(obs_busy[n]),  128'(0));
        chk({tag, "_data"},  obs_data[n],        128'(0));
        chk({tag, "_idx"},   128'(obs_idx[n]),   128'(0));
        chk({tag, "_last"},  128'(obs_last[n]),  128'(0));
    endtask

    // Starts a sequence at the current negedge and follows it beat by beat.
    // abort_pos >= 0 aborts (together with an accept) at that consumption position.
    task automatic run_seq(input int n, input bit d, input bit rnd, input int abort_pos);
        int lanes;
        int pos;
        int cycles;
        int i;
        lanes = lanes_of(n);
        pos = 0;
        cycles = 0;
        start_v[n] = 1'b1;
        dir_v[n]   = d;
        ready_v[n] = 1'b0;
        cyc();
        start_v[n] = 1'b0;
        while (pos < NR) begin
            if (cycles > 400) begin
                chk("seq_timeout", 128'(1), 128'(0));
                break;
            end
            cycles++;
            i = d ? NR - 1 - pos : pos;
            chk("beat_valid", 128'(obs_valid[n]), 128'(1));
            chk("beat_busy",  128'(obs_busy[n]),  128'(1));
            chk("beat_idx",   128'(obs_idx[n]),   128'(i));
            chk("beat_data",  obs_data[n],        beat_ref(i, lanes, d));
            chk("beat_last",  128'(obs_last[n]),  128'(pos + lanes >= NR));
            chk("beat_nodone", 128'(obs_done[n]), 128'(0));
            if (pos == abort_pos) begin
                abort_v[n] = 1'b1;
                ready_v[n] = 1'b1;
                cyc();
                abort_v[n] = 1'b0;
                ready_v[n] = 1'b0;
                chk_idle(n, "abort");
                chk("abort_nodone0", 128'(obs_done[n]), 128'(0));
                cyc();
                chk("abort_nodone1", 128'(obs_done[n]), 128'(0));
                return;
            end
            ready_v[n] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rnd) begin
                start_v[n] = 1'($urandom_range(0, 1));
                dir_v[n]   = 1'($urandom_range(0, 1));
            end
            cyc();
            if (ready_v[n]) pos += lanes;
        end
        start_v[n] = 1'b0;
        ready_v[n] = 1'b0;
        chk("end_done", 128'(obs_done[n]), 128'(1));
        chk_idle(n, "end");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int n = 0; n < 3; n++) begin
            start_v[n] = 1'b0; dir_v[n] = 1'b0; abort_v[n] = 1'b0; ready_v[n] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            chk_idle(n, "reset");
            chk("reset_done", 128'(obs_done[n]), 128'(0));
        end
        rst = 1'b0;

        // Forward LANES=1 starting on the first edge after reset release.
        run_seq(0, 1'b0, 1'b0, -1);
        // Start in the done cycle chains straight into a new sequence.
        run_seq(0, 1'b0, 1'b0, -1);
        cyc();
        chk("done_pulse_width", 128'(obs_done[0]), 128'(0));

        // LANES=4 reverse, then random stalls on LANES=2 and LANES=4.
        run_seq(2, 1'b1, 1'b0, -1);
        cyc();
        chk("l4_done_width", 128'(obs_done[2]), 128'(0));
        run_seq(1, 1'b0, 1'b1, -1);
        cyc();
        run_seq(1, 1'b1, 1'b1, -1);
        cyc();
        run_seq(2, 1'b0, 1'b1, -1);
        cyc();

        // Abort coincident with accept at round 10, then abort blocking start in IDLE.
        run_seq(0, 1'b0, 1'b0, 10);
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        cyc();
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        chk_idle(0, "idle_abort");
        run_seq(0, 1'b0, 1'b1, -1);
        cyc();

        // Asynchronous reset between edges in the middle of a LANES=2 reverse run.
        start_v[1] = 1'b1;
        dir_v[1]   = 1'b1;
        ready_v[1] = 1'b1;
        cyc();
        start_v[1] = 1'b0;
        repeat (3) cyc();
        chk("pre_rst_valid", 128'(obs_valid[1]), 128'(1));
        #2 rst = 1'b1;
        #1;
        chk_idle(1, "async_rst");
        chk("async_rst_done", 128'(obs_done[1]), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        ready_v[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("post_rst_done", 128'(obs_done[1]), 128'(0));
            chk("post_rst_valid", 128'(obs_valid[1]), 128'(0));
        end
        run_seq(1, 1'b1, 1'b0, -1);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
